icache_direct: RTL and testbench
================================

# icache_direct

Parametrised, direct-mapped, read-only instruction cache between the CPU fetch port (PC / INSTRUCTION / BUSYWAIT) and a slow block-wide instruction memory. It is the successor to the fixed testbench byte-array instruction fetch: it adds configurable line count and block size, a miss FSM with a busywait handshake toward the memory, and a global invalidate. Hits return the instruction in the same cycle with no stall. Misses stall the CPU via BUSYWAIT until the block is refilled.

## Interface
- ADDR_W, 10: byte-address width of PC used by the cache (1024-byte instruction space).
- LINES, 8: number of cache lines; power of two, ≥2.
- WORDS, 4: 32-bit words per block; power of two, ≥1.
- CLK  in  1  rising-edge clock; one clock domain.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  ADDR_W  byte fetch address; bits [1:0] ignored.
- INSTRUCTION  out  32  fetched word; valid whenever BUSYWAIT=0.
- BUSYWAIT  out  1  CPU must hold PC and stall while high.
- INVALIDATE  in  1  single-cycle pulse; clears all valid bits.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  ADDR_W-log2(4*WORDS)  block address (tag,index) of the missed line.
- MEM_READDATA  in  32*WORDS  refill block; word 0 in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; data valid on the first sampled low.

## Operation
- Address split: offset = PC[log2(4*WORDS)-1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Storage: per line valid bit, tag, and a 32*WORDS data block.
- Hit = valid[index] && tag[index]==tag. On a hit, INSTRUCTION = the selected word, combinationally.
- FSM states:
  - IDLE: on a miss, assert BUSYWAIT combinationally, latch {tag,index}, and go to MEM_READ at the next edge.
  - MEM_READ: MEM_READ=1, MEM_ADDRESS = latched value, BUSYWAIT=1. Go to UPDATE at the first edge where MEM_BUSYWAIT=0, after at least one full cycle in this state.
  - UPDATE: BUSYWAIT=1. At the edge, write the block, tag and valid=1 to the latched index, then go to IDLE.
- The refill always uses the latched address. A PC change during a miss does not affect the fill.
- INVALIDATE clears every valid bit at the edge where it is sampled high, in any state.
  - If it coincides with the UPDATE edge, invalidate wins: the line is left invalid and the FSM goes to IDLE, which re-misses.
  - If it is asserted during MEM_READ, the fill continues.
- Reset (RESET=0, asynchronous):
  - State = IDLE; all valid bits = 0; MEM_READ=0; MEM_ADDRESS=0.
  - BUSYWAIT=0 and INSTRUCTION=0 while reset is held.
  - Tag and data arrays are not cleared.
  - Reset mid-fill aborts the fill; nothing is written.

## Timing
- Hit latency: 0 cycles; INSTRUCTION settles in the same cycle PC is presented.
- Miss with memory data after L cycles (MEM_BUSYWAIT high for L-1 sampled edges, then low): BUSYWAIT is high for exactly L+2 cycles (1 IDLE + L MEM_READ + 1 UPDATE). The hit is served in the following IDLE cycle.
- MEM_READ is registered: it rises one edge after the miss is detected and falls at the MEM_READ→UPDATE edge.
- Back-to-back misses: each miss passes through IDLE for one cycle; there is no pipelining.

## Structure
- Shared package icache_pkg holds:
  - the state enum {IDLE, MEM_READ, UPDATE};
  - localparam functions for OFFSET_W, INDEX_W and TAG_W derived from ADDR_W, LINES and WORDS.
- Sub-module icache_line_store holds the valid, tag and data arrays:
  - async-clear valid;
  - one synchronous write port;
  - one combinational read port indexed by index.
- The top level holds the FSM, the address latch and word selection.

## Test plan
- Defaults with L=5:
  - Cold miss: after reset, PC=0x000 → BUSYWAIT high for 7 cycles; MEM_ADDRESS=0x00 during MEM_READ; INSTRUCTION = word 0 of the block.
  - Spatial hits: then PC=0x004, 0x008, 0x00C → BUSYWAIT stays 0 and words 1–3 appear in the same cycle.
  - Conflict: PC=0x080 (index 0, new tag) → miss, 7-cycle stall, line replaced. PC=0x000 then misses again.
- Invalidate: with the line at 0x000 cached, pulse INVALIDATE, then PC=0x000 → miss, MEM_READ rises. Pulse INVALIDATE on the UPDATE edge → the line stays invalid and a re-miss follows.
- Reset mid-fill: drive RESET low for 1 cycle during MEM_READ → MEM_READ=0 immediately and valid[0]=0. After release, PC=0x000 → fresh miss.
- Parameter sweep with LINES=16, WORDS=2:
  - PC=0x0F8 → index 15, offset word 0; refill address 0x1F.
  - PC=0x0FC → hit returning word 1.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared miss-FSM state type and address-split width helpers for icache_direct
package icache_pkg;
  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
  function automatic int offset_w(input int words);
    return $clog2(4 * words);
  endfunction
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - offset_w(words) - index_w(lines);
  endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays; ports clk, reset (async low), invalidate, write port (we, waddr, wtag, wdata), comb read port (raddr -> rvalid, rtag, rdata)
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int TAG_W = 3,
  parameter int BLK_W = 128,
  localparam int INDEX_W = index_w(LINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               invalidate,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [BLK_W-1:0]   wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [BLK_W-1:0]   rdata
);
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [BLK_W-1:0] data [LINES];
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid <= '0;
    else if (invalidate) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[waddr] <= wtag;
      data[waddr] <= wdata;
    end
  assign rvalid = valid[raddr];
  assign rtag = tags[raddr];
  assign rdata = data[raddr];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only icache; ports clk, reset (async low), pc/instruction/busywait (CPU), invalidate, mem_read/mem_address/mem_readdata/mem_busywait (block memory)
module icache_direct
  import icache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_W-1:0]                    pc,
  output logic [31:0]                          instruction,
  output logic                                 busywait,
  input  logic                                 invalidate,
  output logic                                 mem_read,
  output logic [ADDR_W-offset_w(WORDS)-1:0]    mem_address,
  input  logic [32*WORDS-1:0]                  mem_readdata,
  input  logic                                 mem_busywait
);
  localparam int OFFSET_W = offset_w(WORDS);
  localparam int INDEX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
  localparam int BLK_W = 32 * WORDS;
  state_t state;
  logic [OFFSET_W-1:0] boff, word;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0] tag, rtag;
  logic [BLK_W-1:0] rdata, shifted;
  logic rvalid, hit;
  assign boff = pc[OFFSET_W-1:0];
  assign word = boff >> 2;
  assign index = pc[OFFSET_W +: INDEX_W];
  assign tag = pc[ADDR_W-1 -: TAG_W];
  assign hit = rvalid && rtag == tag;
  assign shifted = rdata >> {word, 5'd0};
  assign instruction = reset ? shifted[31:0] : 32'd0;
  assign busywait = reset && (state != IDLE || !hit);
  icache_line_store #(.LINES(LINES), .TAG_W(TAG_W), .BLK_W(BLK_W)) u_store (
    .clk(clk),
    .reset(reset),
    .invalidate(invalidate),
    .we(state == UPDATE),
    .waddr(mem_address[INDEX_W-1:0]),
    .wtag(mem_address[INDEX_W +: TAG_W]),
    .wdata(mem_readdata),
    .raddr(index),
    .rvalid(rvalid),
    .rtag(rtag),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      mem_read <= 1'b0;
      mem_address <= '0;
    end else
      case (state)
        IDLE: if (!hit) begin
          state <= MEM_READ;
          mem_read <= 1'b1;
          mem_address <= {tag, index};
        end
        MEM_READ: if (!mem_busywait) begin
          state <= UPDATE;
          mem_read <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: self-checking bench for icache_direct (default and LINES=16/WORDS=2 instances)
module tb_icache_direct;
  logic clk = 1'b0, reset = 1'b0, inv = 1'b0;
  logic [9:0] pc0 = '0, pc1 = '0;
  logic [31:0] ins0, ins1;
  logic bw0, bw1, mr0, mr1, mb0, mb1;
  logic [5:0] ma0;
  logic [6:0] ma1;
  logic [127:0] rd0;
  logic [63:0] rd1;
  int lat0 = 5, lat1 = 4, c0 = 0, c1 = 0, checks = 0, errors = 0;
  logic mv [8];
  logic [2:0] mt [8];
  logic [9:0] curpc;
  typedef struct {logic [9:0] pc; int lat; bit miss; logic [9:0] ma;} vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  icache_direct u0 (
    .clk(clk), .reset(reset), .pc(pc0), .instruction(ins0), .busywait(bw0),
    .invalidate(inv), .mem_read(mr0), .mem_address(ma0), .mem_readdata(rd0), .mem_busywait(mb0)
  );
  icache_direct #(.ADDR_W(10), .LINES(16), .WORDS(2)) u1 (
    .clk(clk), .reset(reset), .pc(pc1), .instruction(ins1), .busywait(bw1),
    .invalidate(inv), .mem_read(mr1), .mem_address(ma1), .mem_readdata(rd1), .mem_busywait(mb1)
  );

  function automatic logic [31:0] mem_val(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a[9:2], 2'b00};
  endfunction

  always_comb begin
    rd0 = '0;
    for (int w = 0; w < 4; w++) rd0[32*w +: 32] = mem_val({ma0, 2'(w), 2'b00});
  end
  always_comb begin
    rd1 = '0;
    for (int w = 0; w < 2; w++) rd1[32*w +: 32] = mem_val({ma1, 1'(w), 2'b00});
  end
  always @(posedge clk) c0 <= mr0 ? c0 + 1 : 0;
  always @(posedge clk) c1 <= mr1 ? c1 + 1 : 0;
  assign mb0 = mr0 && (c0 < lat0 - 1);
  assign mb1 = mr1 && (c1 < lat1 - 1);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_fill(input bit d, output int n, output logic [9:0] ma);
    n = 0;
    ma = '1;
    #1;
    while ((d ? bw1 : bw0) && n < 100) begin
      if (d ? mr1 : mr0) ma = d ? {3'b0, ma1} : {4'b0, ma0};
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic fetch(input bit d, input logic [9:0] a, input int exp_n, input logic [9:0] exp_ma, input string nm);
    int n;
    logic [9:0] ma;
    if (d) pc1 = a;
    else pc0 = a;
    wait_fill(d, n, ma);
    chk({nm, "_stall"}, n, exp_n);
    chk({nm, "_instr"}, d ? ins1 : ins0, mem_val(a));
    if (exp_n > 0) chk({nm, "_maddr"}, {22'd0, ma}, {22'd0, exp_ma});
    @(negedge clk);
  endtask

  task automatic inv_fill(input string nm);
    int n;
    logic [9:0] ma;
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    wait_fill(0, n, ma);
    chk({nm, "_stall"}, n, lat0 + 2);
    chk({nm, "_maddr"}, {22'd0, ma}, {22'd0, pc0 >> 4});
    chk({nm, "_instr"}, ins0, mem_val(pc0));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [9:0] ma;
    tbl[0]  = '{10'h000, 5, 1'b1, 10'h00};
    tbl[1]  = '{10'h004, 5, 1'b0, 10'h00};
    tbl[2]  = '{10'h008, 5, 1'b0, 10'h00};
    tbl[3]  = '{10'h00C, 5, 1'b0, 10'h00};
    tbl[4]  = '{10'h00E, 5, 1'b0, 10'h00};
    tbl[5]  = '{10'h080, 5, 1'b1, 10'h08};
    tbl[6]  = '{10'h000, 5, 1'b1, 10'h00};
    tbl[7]  = '{10'h104, 1, 1'b1, 10'h10};
    tbl[8]  = '{10'h100, 1, 1'b0, 10'h00};
    tbl[9]  = '{10'h3FC, 3, 1'b1, 10'h3F};
    tbl[10] = '{10'h3F0, 3, 1'b0, 10'h00};
    #2;
    chk("rst_busy", {31'd0, bw0}, 0);
    chk("rst_instr", ins0, 0);
    chk("rst_memread", {31'd0, mr0}, 0);
    chk("rst_maddr", {26'd0, ma0}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[i]) begin
      lat0 = tbl[i].lat;
      fetch(0, tbl[i].pc, tbl[i].miss ? tbl[i].lat + 2 : 0, tbl[i].ma, $sformatf("vec%0d", i));
    end
    fetch(0, 10'h000, lat0 + 2, 10'h00, "inv_pre");
    fetch(0, 10'h000, 0, 10'h00, "inv_hit");
    inv_fill("inv");
    pc0 = 10'h040;
    n = 0;
    #1;
    begin
      bit seen = 1'b0;
      while (!(seen && bw0 && !mr0) && n < 100) begin
        seen |= mr0;
        n++;
        @(negedge clk);
        #1;
      end
    end
    chk("upd_reach", {31'd0, n < 100}, 1);
    inv = 1'b1;
    @(negedge clk);
    #1;
    inv = 1'b0;
    chk("upd_inv_busy", {31'd0, bw0}, 1);
    chk("upd_inv_idle", {31'd0, mr0}, 0);
    @(negedge clk);
    #1;
    chk("upd_inv_remiss", {31'd0, mr0}, 1);
    wait_fill(0, n, ma);
    chk("upd_inv_done", {31'd0, bw0}, 0);
    chk("upd_inv_instr", ins0, mem_val(10'h040));
    @(negedge clk);
    pc0 = 10'h000;
    n = 0;
    #1;
    while (!mr0 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mid_reach", {31'd0, mr0}, 1);
    reset = 1'b0;
    #1;
    chk("mid_memread", {31'd0, mr0}, 0);
    chk("mid_busy", {31'd0, bw0}, 0);
    chk("mid_instr", ins0, 0);
    chk("mid_maddr", {26'd0, ma0}, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_fill(0, n, ma);
    chk("mid_refill_stall", n, lat0 + 2);
    chk("mid_refill_instr", ins0, mem_val(10'h000));
    @(negedge clk);
    foreach (mv[i]) mv[i] = 1'b0;
    mv[0] = 1'b1;
    mt[0] = 3'd0;
    curpc = 10'h000;
    for (int i = 0; i < 80; i++) begin
      lat0 = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) begin
        foreach (mv[k]) mv[k] = 1'b0;
        mv[(int'(curpc) / 16) % 8] = 1'b1;
        mt[(int'(curpc) / 16) % 8] = 3'((int'(curpc) / 16) / 8);
        inv_fill($sformatf("rinv%0d", i));
      end else begin
        logic [9:0] a;
        int blk, idx, tg;
        a = $urandom_range(0, 1) ? 10'($urandom_range(0, 255)) : 10'($urandom_range(0, 1023));
        blk = int'(a) / 16;
        idx = blk % 8;
        tg = blk / 8;
        fetch(0, a, (mv[idx] && int'(mt[idx]) == tg) ? 0 : lat0 + 2, 10'(blk), $sformatf("rnd%0d", i));
        mv[idx] = 1'b1;
        mt[idx] = 3'(tg);
        curpc = a;
      end
    end
    repeat (10) @(negedge clk);
    fetch(1, 10'h0F8, lat1 + 2, 10'h1F, "sw_miss");
    fetch(1, 10'h0FC, 0, 10'h00, "sw_hit");
    fetch(1, 10'h0F4, lat1 + 2, 10'h1E, "sw_miss2");
    fetch(1, 10'h0F0, 0, 10'h00, "sw_hit2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
